// File: rtl/clk_en_scheduler.sv
`default_nettype none
// ============================================================================
// clk_en_scheduler : shared programmable prescaler, per-channel tick + square
// Revision 1.0
// ============================================================================
module clk_en_scheduler #(
   parameter int N_CH    = 4,
   parameter int DIV_W   = 16,
   parameter int DEF_DIV = 50000,
   localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic [N_CH-1:0]   en_i,
   input  logic              cfg_valid_i,
   output logic              cfg_ready_o,
   input  logic [CH_W-1:0]   cfg_ch_i,
   input  logic [DIV_W-1:0]  cfg_div_i,
   output logic [N_CH-1:0]   tick_o,
   output logic [N_CH-1:0]   sq_o,
   output logic [N_CH-1:0]   pend_o
);

   localparam int NSEL = 1 << CH_W;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RUN      = 2'd1,
      ST_RUN_PEND = 2'd2
   } state_t;

   logic [N_CH-1:0]  pend_vec;
   logic [NSEL-1:0]  pend_sel;
   logic             cfg_fire;
   logic [DIV_W-1:0] cfg_div_clamped;

   // Out-of-range channel indices read as "not pending" so the port never goes X.
   assign pend_sel        = NSEL'(pend_vec);
   assign cfg_ready_o     = rst_n_i & ~pend_sel[cfg_ch_i];
   assign cfg_fire        = cfg_valid_i & cfg_ready_o;
   assign cfg_div_clamped = (cfg_div_i < DIV_W'(2)) ? DIV_W'(2) : cfg_div_i;
   assign pend_o          = pend_vec;

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      state_t           state_q, state_d;
      logic [DIV_W-1:0] cnt_q, cnt_d;
      logic [DIV_W-1:0] div_q, div_d;
      logic [DIV_W-1:0] pdiv_q, pdiv_d;
      logic             tick_q, tick_d;
      logic             sq_q, sq_d;
      logic             cfg_hit;
      logic             wrap;

      assign cfg_hit     = cfg_fire & (cfg_ch_i == CH_W'(g));
      assign wrap        = (cnt_q == div_q - DIV_W'(1));
      assign tick_o[g]   = tick_q;
      assign sq_o[g]     = sq_q;
      assign pend_vec[g] = (state_q == ST_RUN_PEND);

      always_ff @(posedge clk_i or negedge rst_n_i) begin
         if (!rst_n_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            div_q   <= DIV_W'(DEF_DIV);
            pdiv_q  <= '0;
            tick_q  <= 1'b0;
            sq_q    <= 1'b0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            pdiv_q  <= pdiv_d;
            tick_q  <= tick_d;
            sq_q    <= sq_d;
         end
      end

      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         div_d   = div_q;
         pdiv_d  = pdiv_q;
         tick_d  = 1'b0;
         sq_d    = sq_q;
         case (state_q)
            ST_IDLE: begin
               cnt_d = '0;
               sq_d  = 1'b0;
               if (cfg_hit) div_d = cfg_div_clamped;
               if (en_i[g]) state_d = ST_RUN;
            end
            ST_RUN: begin
               if (!en_i[g]) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
                  sq_d    = 1'b0;
                  if (cfg_hit) div_d = cfg_div_clamped;
               end else if (wrap) begin
                  // A config landing on the wrap edge owns the period that starts now.
                  cnt_d  = '0;
                  tick_d = 1'b1;
                  sq_d   = ~sq_q;
                  if (cfg_hit) div_d = cfg_div_clamped;
               end else begin
                  cnt_d = cnt_q + DIV_W'(1);
                  if (cfg_hit) begin
                     pdiv_d  = cfg_div_clamped;
                     state_d = ST_RUN_PEND;
                  end
               end
            end
            ST_RUN_PEND: begin
               if (!en_i[g]) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
                  sq_d    = 1'b0;
                  div_d   = pdiv_q;
               end else if (wrap) begin
                  state_d = ST_RUN;
                  cnt_d   = '0;
                  tick_d  = 1'b1;
                  sq_d    = ~sq_q;
                  div_d   = pdiv_q;
               end else begin
                  cnt_d = cnt_q + DIV_W'(1);
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               sq_d    = 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_clk_en_scheduler.sv
`default_nettype none
// ============================================================================
// tb_clk_en_scheduler : directed self-checking bench for clk_en_scheduler
// Revision 1.0
// ============================================================================
module tb_clk_en_scheduler;

   localparam int N_CH    = 4;
   localparam int DIV_W   = 16;
   localparam int DEF_DIV = 10;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [N_CH-1:0]   en = '0;
   logic              cfg_valid = 1'b0;
   logic [1:0]        cfg_ch = '0;
   logic [DIV_W-1:0]  cfg_div = '0;
   logic              cfg_ready;
   logic [N_CH-1:0]   tick;
   logic [N_CH-1:0]   sq;
   logic [N_CH-1:0]   pend;

   int                checks = 0;
   int                errors = 0;
   int                n;
   logic [N_CH-1:0]   pend_seen = '0;

   clk_en_scheduler #(
      .N_CH    (N_CH),
      .DIV_W   (DIV_W),
      .DEF_DIV (DEF_DIV)
   ) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .en_i        (en),
      .cfg_valid_i (cfg_valid),
      .cfg_ready_o (cfg_ready),
      .cfg_ch_i    (cfg_ch),
      .cfg_div_i   (cfg_div),
      .tick_o      (tick),
      .sq_o        (sq),
      .pend_o      (pend)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
      pend_seen = pend_seen | pend;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Cycles until tick_o[ch] is seen high; -1 if it never shows within the budget.
   task automatic wait_tick(input int ch, output int cyc);
      bit found;
      found = 1'b0;
      cyc   = -1;
      for (int i = 1; i <= 40 && !found; i++) begin
         step();
         if (tick[ch] === 1'b1) begin
            cyc   = i;
            found = 1'b1;
         end
      end
   endtask

   initial begin
      // Reset state
      step(); step();
      check("rst_tick", 32'(tick), 0);
      check("rst_sq", 32'(sq), 0);
      check("rst_pend", 32'(pend), 0);
      check("rst_ready", 32'(cfg_ready), 0);
      rst_n = 1'b1;
      #1;
      check("ready_after_rst", 32'(cfg_ready), 1);

      // Ch0 at default divisor
      en = 4'b0001;
      step();
      wait_tick(0, n);   check("ch0_first_tick", n, 10);
      check("ch0_sq_first", 32'(sq[0]), 1);
      step();
      check("ch0_tick_one_cycle", 32'(tick[0]), 0);
      wait_tick(0, n);   check("ch0_second_tick", n, 9);
      check("ch0_sq_second", 32'(sq[0]), 0);
      en = 4'b0000;
      step();

      // Ch1 configured while idle
      cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 16'd4;
      #1;
      check("ch1_ready_idle", 32'(cfg_ready), 1);
      step();
      cfg_valid = 1'b0;
      en = 4'b0010;
      pend_seen = '0;
      step();
      wait_tick(1, n);   check("ch1_tick_a", n, 4);
      wait_tick(1, n);   check("ch1_tick_b", n, 4);
      check("ch1_never_pend", 32'(pend_seen[1]), 0);
      en = 4'b0000;
      step();

      // Ch0 reprogrammed mid-period
      en = 4'b0001;
      step();
      step(); step(); step();
      cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd5;
      #1;
      check("ch0_ready_run", 32'(cfg_ready), 1);
      step();
      check("ch0_pend_set", 32'(pend[0]), 1);
      check("ch0_ready_blocked", 32'(cfg_ready), 0);
      cfg_ch = 2'd1;
      #1;
      check("ch1_ready_while_ch0_pend", 32'(cfg_ready), 1);
      cfg_valid = 1'b0;
      wait_tick(0, n);   check("ch0_old_period_end", n, 6);
      check("ch0_pend_clear", 32'(pend[0]), 0);
      wait_tick(0, n);   check("ch0_new_period_a", n, 5);
      wait_tick(0, n);   check("ch0_new_period_b", n, 5);
      en = 4'b0000;
      step();

      // Ch2 divisor 1 clamps to 2
      cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 16'd1;
      step();
      cfg_valid = 1'b0;
      en = 4'b0100;
      step();
      wait_tick(2, n);   check("ch2_clamp_a", n, 2);
      check("ch2_sq_a", 32'(sq[2]), 1);
      wait_tick(2, n);   check("ch2_clamp_b", n, 2);
      check("ch2_sq_b", 32'(sq[2]), 0);
      en = 4'b0000;
      step();

      // Config landing on ch0's wrap edge
      cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd6;
      step();
      cfg_valid = 1'b0;
      en = 4'b0001;
      step();
      wait_tick(0, n);   check("ch0_d6_tick", n, 6);
      step(); step(); step(); step(); step();
      cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd3;
      #1;
      check("ch0_ready_wrap", 32'(cfg_ready), 1);
      step();
      check("ch0_wrap_tick", 32'(tick[0]), 1);
      check("ch0_wrap_no_pend", 32'(pend[0]), 0);
      cfg_valid = 1'b0;
      pend_seen = '0;
      wait_tick(0, n);   check("ch0_d3_a", n, 3);
      wait_tick(0, n);   check("ch0_d3_b", n, 3);
      check("ch0_wrap_pend_never", 32'(pend_seen[0]), 0);

      // Disable while pending applies the pending divisor
      step();
      cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd7;
      step();
      cfg_valid = 1'b0;
      check("ch0_pend_before_dis", 32'(pend[0]), 1);
      en = 4'b0000;
      step();
      check("dis_tick", 32'(tick[0]), 0);
      check("dis_sq", 32'(sq[0]), 0);
      check("dis_pend", 32'(pend[0]), 0);
      en = 4'b0001;
      step();
      wait_tick(0, n);   check("ch0_applied_d7", n, 7);

      // Async reset mid-period with a pending value
      step(); step();
      cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd4;
      step();
      cfg_valid = 1'b0;
      check("ch0_pend_before_rst", 32'(pend[0]), 1);
      check("ch0_sq_before_rst", 32'(sq[0]), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_tick", 32'(tick), 0);
      check("arst_sq", 32'(sq), 0);
      check("arst_pend", 32'(pend), 0);
      check("arst_ready", 32'(cfg_ready), 0);
      step(); step();
      rst_n = 1'b1;
      step();
      wait_tick(0, n);   check("ch0_def_restored", n, 10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
